// File: rtl/variable_node.sv
// -----------------------------------------------------------------------------
// variable_node
//
// Serial non-binary LDPC variable node over GF(4). For each symbol it takes one
// channel LLR vector, then VAR_DEGREE check-to-variable messages, and returns
// VAR_DEGREE extrinsic variable-to-check messages (in arrival order) together
// with a hard symbol decision.
//
// LLR vector layout: FIELD signed entries for the nonzero symbols 1..FIELD,
// entry e at bits [e*LLR_BIT +: LLR_BIT]; the zero symbol is implicitly 0.
//
// Ports
//   clk            clock, all state on posedge
//   rst            synchronous active-high reset, aborts any symbol in flight
//   chan_valid     channel vector present (taken only when idle)
//   chan_llr       channel LLR vector
//   in_valid       check message valid
//   in_ready       high while collecting check messages
//   in_llr         check-to-variable message
//   out_valid      high while emitting extrinsic messages
//   out_ready      consumer accepts out_llr
//   out_llr        extrinsic message
//   out_last       marks the VAR_DEGREE-th extrinsic message
//   decision       hard decision 0..3, held until the next symbol completes
//   decision_valid one-cycle pulse on the first emit cycle
// -----------------------------------------------------------------------------
module variable_node #(
    parameter int VAR_DEGREE = 3,
    parameter int FIELD      = 3,
    parameter int LLR_BIT    = 3,
    parameter int ACC_BIT    = 6,
    parameter int SYMBOL_BIT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     chan_valid,
    input  logic [FIELD*LLR_BIT-1:0] chan_llr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FIELD*LLR_BIT-1:0] in_llr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FIELD*LLR_BIT-1:0] out_llr,
    output logic                     out_last,
    output logic [SYMBOL_BIT-1:0]    decision,
    output logic                     decision_valid
);

    localparam int K_BIT = (VAR_DEGREE > 1) ? $clog2(VAR_DEGREE) : 1;
    localparam logic [K_BIT-1:0] K_LAST = K_BIT'(VAR_DEGREE - 1);

    // Saturation bounds expressed at the ACC_BIT+1 working width so that all
    // comparisons happen on one signed width.
    localparam logic signed [ACC_BIT:0] ACC_MAX_W = (ACC_BIT+1)'((2**(ACC_BIT-1)) - 1);
    localparam logic signed [ACC_BIT:0] ACC_MIN_W = (ACC_BIT+1)'(-(2**(ACC_BIT-1)));
    localparam logic signed [ACC_BIT:0] LLR_MAX_W = (ACC_BIT+1)'((2**(LLR_BIT-1)) - 1);
    localparam logic signed [ACC_BIT:0] LLR_MIN_W = (ACC_BIT+1)'(-(2**(LLR_BIT-1)));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers: widen to the working width and clip back down
    // -------------------------------------------------------------------------
    function automatic logic signed [ACC_BIT:0] ext_llr(input logic [LLR_BIT-1:0] v);
        return $signed({{(ACC_BIT+1-LLR_BIT){v[LLR_BIT-1]}}, v});
    endfunction

    function automatic logic signed [ACC_BIT:0] ext_acc(input logic [ACC_BIT-1:0] v);
        return $signed({v[ACC_BIT-1], v});
    endfunction

    function automatic logic [ACC_BIT-1:0] sat_acc(input logic signed [ACC_BIT:0] v);
        logic [ACC_BIT-1:0] r;
        if (v > ACC_MAX_W) begin
            r = ACC_MAX_W[ACC_BIT-1:0];
        end else if (v < ACC_MIN_W) begin
            r = ACC_MIN_W[ACC_BIT-1:0];
        end else begin
            r = v[ACC_BIT-1:0];
        end
        return r;
    endfunction

    function automatic logic [LLR_BIT-1:0] sat_llr(input logic signed [ACC_BIT:0] v);
        logic [LLR_BIT-1:0] r;
        if (v > LLR_MAX_W) begin
            r = LLR_MAX_W[LLR_BIT-1:0];
        end else if (v < LLR_MIN_W) begin
            r = LLR_MIN_W[LLR_BIT-1:0];
        end else begin
            r = v[LLR_BIT-1:0];
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                   state_reg;
    logic [ACC_BIT-1:0]       acc_reg     [FIELD];
    logic [LLR_BIT-1:0]       msg_buf_reg [VAR_DEGREE][FIELD];
    logic [K_BIT-1:0]         k_reg;
    logic                     in_ready_reg;
    logic                     out_valid_reg;
    logic                     out_last_reg;
    logic [FIELD*LLR_BIT-1:0] out_llr_reg;
    logic [SYMBOL_BIT-1:0]    decision_reg;
    logic                     decision_valid_reg;

    // -------------------------------------------------------------------------
    // Per-entry datapath
    // -------------------------------------------------------------------------
    logic [ACC_BIT-1:0]       chan_ext [FIELD];
    logic [LLR_BIT-1:0]       in_ent   [FIELD];
    logic [ACC_BIT-1:0]       acc_upd  [FIELD];
    logic [FIELD*LLR_BIT-1:0] first_out;
    logic [FIELD*LLR_BIT-1:0] next_out;
    logic [K_BIT-1:0]         k_next;

    // Index of the message that follows the one currently presented; wraps to
    // zero so the buffer read never leaves the array.
    assign k_next = (k_reg == K_LAST) ? '0 : k_reg + K_BIT'(1);

    for (genvar gi = 0; gi < FIELD; gi++) begin : g_entry
        logic [LLR_BIT-1:0] chan_e;

        assign chan_e       = chan_llr[gi*LLR_BIT +: LLR_BIT];
        assign chan_ext[gi] = {{(ACC_BIT-LLR_BIT){chan_e[LLR_BIT-1]}}, chan_e};
        assign in_ent[gi]   = in_llr[gi*LLR_BIT +: LLR_BIT];
        assign acc_upd[gi]  = sat_acc(ext_acc(acc_reg[gi]) + ext_llr(in_ent[gi]));

        // First extrinsic output is formed from the accumulator as it will be
        // after the final message, so it can be registered on that same edge.
        // Slot 0 of the buffer is already filled because VAR_DEGREE >= 2.
        assign first_out[gi*LLR_BIT +: LLR_BIT] =
            sat_llr(ext_acc(acc_upd[gi]) - ext_llr(msg_buf_reg[0][gi]));

        // Subsequent outputs use the settled accumulator.
        assign next_out[gi*LLR_BIT +: LLR_BIT] =
            sat_llr(ext_acc(acc_reg[gi]) - ext_llr(msg_buf_reg[k_next][gi]));
    end

    // -------------------------------------------------------------------------
    // Hard decision from the post-update accumulator. Zero symbol starts as the
    // incumbent with value 0; strict '>' keeps ties on the lower symbol index.
    // -------------------------------------------------------------------------
    logic signed [ACC_BIT:0] best_val;
    logic [SYMBOL_BIT-1:0]   best_sym;

    always_comb begin
        best_val = '0;
        best_sym = '0;
        for (int e = 0; e < FIELD; e++) begin
            if (ext_acc(acc_upd[e]) > best_val) begin
                best_val = ext_acc(acc_upd[e]);
                best_sym = SYMBOL_BIT'(e + 1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        decision_valid_reg <= 1'b0;
        if (rst) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_llr_reg   <= '0;
            decision_reg  <= '0;
            for (int e = 0; e < FIELD; e++) begin
                acc_reg[e] <= '0;
            end
            for (int d = 0; d < VAR_DEGREE; d++) begin
                for (int e = 0; e < FIELD; e++) begin
                    msg_buf_reg[d][e] <= '0;
                end
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (chan_valid) begin
                        for (int e = 0; e < FIELD; e++) begin
                            acc_reg[e] <= chan_ext[e];
                        end
                        k_reg        <= '0;
                        in_ready_reg <= 1'b1;
                        state_reg    <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (in_valid && in_ready_reg) begin
                        for (int e = 0; e < FIELD; e++) begin
                            msg_buf_reg[k_reg][e] <= in_ent[e];
                            acc_reg[e]            <= acc_upd[e];
                        end
                        if (k_reg == K_LAST) begin
                            k_reg              <= '0;
                            in_ready_reg       <= 1'b0;
                            out_valid_reg      <= 1'b1;
                            out_llr_reg        <= first_out;
                            out_last_reg       <= 1'b0;
                            decision_reg       <= best_sym;
                            decision_valid_reg <= 1'b1;
                            state_reg          <= EMIT;
                        end else begin
                            k_reg <= k_reg + K_BIT'(1);
                        end
                    end
                end

                EMIT: begin
                    if (out_ready) begin
                        if (k_reg == K_LAST) begin
                            k_reg         <= '0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            out_llr_reg   <= '0;
                            state_reg     <= IDLE;
                        end else begin
                            k_reg        <= k_next;
                            out_llr_reg  <= next_out;
                            out_last_reg <= (k_next == K_LAST);
                        end
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_reg;
    assign out_valid      = out_valid_reg;
    assign out_last       = out_last_reg;
    assign out_llr        = out_llr_reg;
    assign decision       = decision_reg;
    assign decision_valid = decision_valid_reg;

endmodule

// File: tb/tb_variable_node.sv
module tb_variable_node;

    localparam int D = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       chan_valid;
    logic [8:0] chan_llr;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_llr;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_llr;
    logic       out_last;
    logic [1:0] decision;
    logic       decision_valid;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int sym_expected = 0;
    int dec_pulses = 0;

    logic [9:0] exp_q[$];   // {last, llr}
    logic [1:0] dec_q[$];
    logic [9:0] mon_e;
    logic [1:0] mon_d;

    variable_node #(
        .VAR_DEGREE(D), .FIELD(3), .LLR_BIT(3), .ACC_BIT(6), .SYMBOL_BIT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .chan_valid(chan_valid),
        .chan_llr(chan_llr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_llr(in_llr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_llr(out_llr),
        .out_last(out_last),
        .decision(decision),
        .decision_valid(decision_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [8:0] v3(input int a, input int b, input int c);
        logic [2:0] x;
        logic [2:0] y;
        logic [2:0] z;
        x = a[2:0];
        y = b[2:0];
        z = c[2:0];
        return {z, y, x};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, pops on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("out  llr=%03h last=%b (want %03h/%b) t=%0d",
                             out_llr, out_last, mon_e[8:0], mon_e[9], cyc);
                    chk("out_llr", out_llr, mon_e[8:0]);
                    chk("out_last", out_last, mon_e[9]);
                end
            end
            if (decision_valid) begin
                dec_pulses++;
                if (dec_q.size() == 0) begin
                    chk("unexpected_decision", dec_q.size(), 1);
                end else begin
                    mon_d = dec_q.pop_front();
                    $display("dec  %0d (want %0d) t=%0d", decision, mon_d, cyc);
                    chk("decision", decision, mon_d);
                end
            end
        end
    end

    task automatic send_msg(input logic [8:0] v);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_llr = v;
        for (int n = 0; n < 20 && !done; n++) begin
            done = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("in_accept", done, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((in_ready || out_valid) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_reached", (in_ready || out_valid), 0);
    endtask

    task automatic run_symbol(input logic [8:0] ch,
                              input logic [8:0] m0, input logic [8:0] m1, input logic [8:0] m2,
                              input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2,
                              input logic [1:0] dec,
                              input bit gaps, input bit stall, input bit noise);
        int t_chan;
        logic [8:0] msgs[3];
        msgs[0] = m0; msgs[1] = m1; msgs[2] = m2;
        wait_idle();
        exp_q.push_back({1'b0, e0});
        exp_q.push_back({1'b0, e1});
        exp_q.push_back({1'b1, e2});
        dec_q.push_back(dec);
        sym_expected++;

        chan_valid = 1'b1;
        chan_llr = ch;
        if (noise) begin
            in_valid = 1'b1;
            in_llr = v3(3, 3, 3);
        end
        @(posedge clk); #1;
        chan_valid = 1'b0;
        in_valid = 1'b0;
        t_chan = cyc;
        chk("in_ready_after_chan", in_ready, 1);
        chk("out_valid_in_collect", out_valid, 0);

        for (int i = 0; i < D; i++) begin
            if (gaps) begin
                @(posedge clk); #1;
            end
            if (noise && i == 1) begin
                chan_valid = 1'b1;
                chan_llr = v3(-4, -4, -4);
            end
            send_msg(msgs[i]);
            chan_valid = 1'b0;
        end

        chk("out_valid_first_emit", out_valid, 1);
        chk("dec_valid_first_emit", decision_valid, 1);
        chk("in_ready_in_emit", in_ready, 0);
        if (!gaps) chk("latency_first_out", cyc - t_chan, D);

        if (noise) begin
            in_valid = 1'b1;
            in_llr = v3(3, 3, 3);
            chan_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chan_valid = 1'b0;
        end

        if (stall) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int s = 0; s < 2; s++) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_llr", out_llr, e1);
                chk("stall_last", out_last, 0);
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end

        wait_idle();
        if (!gaps && !stall && !noise) chk("latency_idle", cyc - t_chan, 2 * D);
        chk("decision_hold", decision, dec);
    endtask

    initial begin
        rst = 1'b1;
        chan_valid = 1'b0;
        chan_llr = '0;
        in_valid = 1'b0;
        in_llr = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_llr", out_llr, 0);
        chk("rst_decision", decision, 0);
        chk("rst_decision_valid", decision_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic case
        run_symbol(v3(1, 0, -1), v3(1, 1, 0), v3(0, 2, -1), v3(-1, 0, 2),
                   v3(0, 2, 0), v3(1, 1, 1), v3(2, 3, -2), 2'd2, 0, 0, 0);
        // Positive saturation: ACC=12 each, 12-3=9 clips to 3; tie -> symbol 1
        run_symbol(v3(3, 3, 3), v3(3, 3, 3), v3(3, 3, 3), v3(3, 3, 3),
                   v3(3, 3, 3), v3(3, 3, 3), v3(3, 3, 3), 2'd1, 0, 0, 0);
        // Negative saturation: ACC=-16, -16+4=-12 clips to -4; no positive entry
        run_symbol(v3(-4, -4, -4), v3(-4, -4, -4), v3(-4, -4, -4), v3(-4, -4, -4),
                   v3(-4, -4, -4), v3(-4, -4, -4), v3(-4, -4, -4), 2'd0, 0, 0, 0);
        // Backpressure on the second output
        run_symbol(v3(1, 0, -1), v3(1, 1, 0), v3(0, 2, -1), v3(-1, 0, 2),
                   v3(0, 2, 0), v3(1, 1, 1), v3(2, 3, -2), 2'd2, 0, 1, 0);

        // Reset after two of three messages: symbol discarded
        wait_idle();
        chan_valid = 1'b1;
        chan_llr = v3(1, 0, -1);
        @(posedge clk); #1;
        chan_valid = 1'b0;
        send_msg(v3(1, 1, 0));
        send_msg(v3(0, 2, -1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_decision", decision, 0);
        chk("abort_out_llr", out_llr, 0);
        // Basic case again right after the abort
        run_symbol(v3(1, 0, -1), v3(1, 1, 0), v3(0, 2, -1), v3(-1, 0, 2),
                   v3(0, 2, 0), v3(1, 1, 1), v3(2, 3, -2), 2'd2, 0, 0, 0);

        // Tie between symbols 1 and 2: ACC=(2,2,0)
        run_symbol(v3(2, 2, 0), v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, 0),
                   v3(2, 2, 0), v3(2, 2, 0), v3(2, 2, 0), 2'd1, 0, 0, 0);
        // All zero: zero symbol wins
        run_symbol(v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, 0),
                   v3(0, 0, 0), v3(0, 0, 0), v3(0, 0, 0), 2'd0, 0, 0, 0);
        // Basic case with gaps between messages
        run_symbol(v3(1, 0, -1), v3(1, 1, 0), v3(0, 2, -1), v3(-1, 0, 2),
                   v3(0, 2, 0), v3(1, 1, 1), v3(2, 3, -2), 2'd2, 1, 0, 0);
        // Basic case with stray chan_valid / in_valid in the wrong states
        run_symbol(v3(1, 0, -1), v3(1, 1, 0), v3(0, 2, -1), v3(-1, 0, 2),
                   v3(0, 2, 0), v3(1, 1, 1), v3(2, 3, -2), 2'd2, 0, 0, 1);

        repeat (5) @(posedge clk);
        #1;
        chk("idle_at_end_in_ready", in_ready, 0);
        chk("idle_at_end_out_valid", out_valid, 0);
        chk("pending_outputs", exp_q.size(), 0);
        chk("pending_decisions", dec_q.size(), 0);
        chk("decision_pulses", dec_pulses, sym_expected);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
